// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC / instruction-register fetch stage feeding control_unit
module instr_fetch_unit #(
  parameter int                ADDR_W     = 8,
  parameter int                DATA_W     = 8,
  parameter int                MEM_LAT    = 2,
  parameter logic [ADDR_W-1:0] START_ADDR = '0,
  parameter logic [DATA_W-1:0] ENDOP_CODE = DATA_W'(28)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] im_addr,
  output logic              im_rd,
  input  logic [DATA_W-1:0] im_data,
  input  logic              exec_done,
  input  logic              pc_inc,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_val,
  output logic [DATA_W-1:0] ir,
  output logic              ir_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic [15:0]       instr_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_F_ADDR,
    S_F_WAIT,
    S_EXEC,
    S_HALT
  } state_t;

  state_t     state, state_nx;
  logic [2:0] wait_cnt;
  logic       last_wait;

  assign last_wait = (wait_cnt == 3'(MEM_LAT - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    im_rd    = 1'b0;
    busy     = 1'b0;
    ir_valid = 1'b0;
    halted   = 1'b0;
    case (state)
      S_IDLE:   if (start) state_nx = S_F_ADDR;
      S_F_ADDR: begin
        im_rd    = 1'b1;
        busy     = 1'b1;
        state_nx = S_F_WAIT;
      end
      S_F_WAIT: begin
        busy = 1'b1;
        if (last_wait) state_nx = (im_data == ENDOP_CODE) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        ir_valid = 1'b1;
        if (exec_done) state_nx = S_F_ADDR;
      end
      S_HALT: begin
        ir_valid = 1'b1;
        halted   = 1'b1;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // pc is frozen for the whole fetch, so it doubles as the held read address
  assign im_addr = busy ? pc : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= '0;
      ir          <= '0;
      instr_count <= '0;
      wait_cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            pc          <= START_ADDR;
            instr_count <= '0;
          end
        end
        S_F_ADDR: wait_cnt <= '0;
        S_F_WAIT: begin
          wait_cnt <= wait_cnt + 3'd1;
          if (last_wait) begin
            ir <= im_data;
            pc <= pc + ADDR_W'(1);
            if (instr_count != 16'hFFFF) instr_count <= instr_count + 16'd1;
          end
        end
        S_EXEC: begin
          // jump beats operand skip; both land before the next fetch starts
          if (pc_load)     pc <= pc_load_val;
          else if (pc_inc) pc <= pc + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - bench for instr_fetch_unit at three latency/start-address builds
module tb_instr_fetch_unit;

  localparam int         NI = 3;
  localparam int         LAT [NI] = '{2, 1, 4};
  localparam logic [7:0] SA  [NI] = '{8'h00, 8'hFF, 8'h00};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [NI], start [NI], exec_done [NI], pc_inc [NI], pc_load [NI];
  logic [7:0]  pc_load_val [NI], im_data [NI], im_addr [NI], ir [NI], pc [NI];
  logic        im_rd [NI], ir_valid [NI], busy [NI], halted [NI];
  logic [15:0] instr_count [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    instr_fetch_unit #(.MEM_LAT(LAT[g]), .START_ADDR(SA[g])) dut (
      .clk(clk), .rst(rst[g]), .start(start[g]),
      .im_addr(im_addr[g]), .im_rd(im_rd[g]), .im_data(im_data[g]),
      .exec_done(exec_done[g]), .pc_inc(pc_inc[g]), .pc_load(pc_load[g]),
      .pc_load_val(pc_load_val[g]), .ir(ir[g]), .ir_valid(ir_valid[g]),
      .pc(pc[g]), .busy(busy[g]), .halted(halted[g]), .instr_count(instr_count[g])
    );
  end

  // Instruction memory: real data only in the last latency cycle, ENDOP garbage otherwise
  logic [7:0] mem [NI][256];
  int         lat_cnt [NI] = '{0, 0, 0};
  logic [7:0] maddr [NI] = '{8'h00, 8'h00, 8'h00};

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (im_rd[i] === 1'b1) begin
        lat_cnt[i] <= LAT[i];
        maddr[i]   <= im_addr[i];
      end else if (lat_cnt[i] > 0) begin
        lat_cnt[i] <= lat_cnt[i] - 1;
      end
    end
  end

  for (genvar g = 0; g < NI; g++) begin : g_mem
    assign im_data[g] = (lat_cnt[g] == 1) ? mem[g][maddr[g]] : 8'h1C;
  end

  // Model: a fetch lasts 1+LAT cycles and yields mem[pc]; ENDOP parks the unit
  bit         m_known [NI] = '{0, 0, 0};
  bit         m_exec  [NI] = '{0, 0, 0};
  bit         m_halt  [NI] = '{0, 0, 0};
  int         m_left  [NI] = '{0, 0, 0};
  int         m_cnt   [NI] = '{0, 0, 0};
  logic [7:0] m_pc    [NI] = '{8'h00, 8'h00, 8'h00};
  logic [7:0] m_ir    [NI] = '{8'h00, 8'h00, 8'h00};

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (rst[i]) begin
        m_known[i] <= 1'b1;
        m_exec[i]  <= 1'b0;
        m_halt[i]  <= 1'b0;
        m_left[i]  <= 0;
        m_cnt[i]   <= 0;
        m_pc[i]    <= 8'h00;
        m_ir[i]    <= 8'h00;
      end else if (m_known[i] && !m_halt[i]) begin
        if (m_left[i] == 1) begin
          m_left[i] <= 0;
          m_ir[i]   <= mem[i][m_pc[i]];
          m_pc[i]   <= m_pc[i] + 8'd1;
          m_cnt[i]  <= (m_cnt[i] == 65535) ? m_cnt[i] : m_cnt[i] + 1;
          if (mem[i][m_pc[i]] == 8'd28) m_halt[i] <= 1'b1;
          else                          m_exec[i] <= 1'b1;
        end else if (m_left[i] > 1) begin
          m_left[i] <= m_left[i] - 1;
        end else if (m_exec[i]) begin
          if (pc_load[i])     m_pc[i] <= pc_load_val[i];
          else if (pc_inc[i]) m_pc[i] <= m_pc[i] + 8'd1;
          if (exec_done[i]) begin
            m_exec[i] <= 1'b0;
            m_left[i] <= 1 + LAT[i];
          end
        end else if (start[i]) begin
          m_pc[i]   <= SA[i];
          m_cnt[i]  <= 0;
          m_left[i] <= 1 + LAT[i];
        end
      end
    end
  end

  int checks = 0;
  int passes = 0;

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, i, act, exp, $time);
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (m_known[i]) begin
        chk("im_rd",       i, 32'(im_rd[i]),       32'(m_left[i] == 1 + LAT[i]));
        chk("busy",        i, 32'(busy[i]),        32'(m_left[i] > 0));
        chk("im_addr",     i, 32'(im_addr[i]),     (m_left[i] > 0) ? 32'(m_pc[i]) : 32'd0);
        chk("ir_valid",    i, 32'(ir_valid[i]),    32'(m_exec[i] || m_halt[i]));
        chk("halted",      i, 32'(halted[i]),      32'(m_halt[i]));
        chk("ir",          i, 32'(ir[i]),          32'(m_ir[i]));
        chk("pc",          i, 32'(pc[i]),          32'(m_pc[i]));
        chk("instr_count", i, 32'(instr_count[i]), 32'(m_cnt[i]));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int i, input logic ed, input logic inc, input logic ld, input logic [7:0] v);
    exec_done[i] = ed; pc_inc[i] = inc; pc_load[i] = ld; pc_load_val[i] = v;
    @(negedge clk);
    exec_done[i] = 1'b0; pc_inc[i] = 1'b0; pc_load[i] = 1'b0;
  endtask

  task automatic wait_valid(input int i);
    int n = 0;
    while (ir_valid[i] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("wait_valid", i, 32'(ir_valid[i]), 32'd1);
  endtask

  task automatic measure(input int i, output int e);
    start[i] = 1'b1;
    e = 0;
    do begin
      @(negedge clk);
      start[i] = 1'b0;
      e++;
    end while (ir_valid[i] !== 1'b1 && e < 50);
  endtask

  int e;

  initial begin
    for (int i = 0; i < NI; i++) begin
      for (int a = 0; a < 256; a++) mem[i][a] = 8'h01;
      rst[i] = 1'b1; start[i] = 1'b0; exec_done[i] = 1'b0;
      pc_inc[i] = 1'b0; pc_load[i] = 1'b0; pc_load_val[i] = 8'h00;
    end
    mem[0][8'h00] = 8'd1;  mem[0][8'h01] = 8'd2;  mem[0][8'h02] = 8'd3;
    mem[0][8'h03] = 8'd27; mem[0][8'h40] = 8'd9;  mem[0][8'h80] = 8'd7;
    mem[0][8'h81] = 8'd28;
    mem[1][8'hFF] = 8'd1;  mem[1][8'h00] = 8'd28;
    mem[2][8'h00] = 8'h55;

    cyc(3);
    for (int i = 0; i < NI; i++) rst[i] = 1'b0;
    cyc(1);
    chk("reset_pc", 0, 32'(pc[0]), 32'd0);
    chk("reset_ir_valid", 0, 32'(ir_valid[0]), 32'd0);

    // first fetches, MEM_LAT=2
    measure(0, e);
    chk("lat2_edges", 0, 32'(e), 32'd4);
    chk("first_ir", 0, 32'(ir[0]), 32'd1);
    chk("first_pc", 0, 32'(pc[0]), 32'd1);
    pulse(0, 1'b1, 1'b0, 1'b0, 8'h00);
    wait_valid(0);
    chk("second_ir", 0, 32'(ir[0]), 32'd2);
    chk("second_pc", 0, 32'(pc[0]), 32'd2);
    chk("second_cnt", 0, 32'(instr_count[0]), 32'd2);

    // operand skip
    pulse(0, 1'b0, 1'b1, 1'b0, 8'h00);
    pulse(0, 1'b1, 1'b0, 1'b0, 8'h00);
    wait_valid(0);
    chk("skip_ir", 0, 32'(ir[0]), 32'd27);
    chk("skip_pc", 0, 32'(pc[0]), 32'd4);

    // jump together with exec_done
    pulse(0, 1'b1, 1'b0, 1'b1, 8'h40);
    chk("jump_addr", 0, 32'(im_addr[0]), 32'h40);
    chk("jump_rd", 0, 32'(im_rd[0]), 32'd1);
    wait_valid(0);
    chk("jump_ir", 0, 32'(ir[0]), 32'd9);
    chk("jump_pc", 0, 32'(pc[0]), 32'h41);

    // start is ignored outside IDLE
    start[0] = 1'b1; cyc(1); start[0] = 1'b0; cyc(1);
    chk("start_ignored_pc", 0, 32'(pc[0]), 32'h41);

    // pc_load beats pc_inc
    pulse(0, 1'b1, 1'b1, 1'b1, 8'h80);
    chk("prio_addr", 0, 32'(im_addr[0]), 32'h80);
    wait_valid(0);
    chk("prio_pc", 0, 32'(pc[0]), 32'h81);

    // ENDOP
    pulse(0, 1'b1, 1'b0, 1'b0, 8'h00);
    wait_valid(0);
    chk("halt_flag", 0, 32'(halted[0]), 32'd1);
    chk("halt_ir", 0, 32'(ir[0]), 32'd28);
    chk("halt_cnt", 0, 32'(instr_count[0]), 32'd6);
    start[0] = 1'b1;
    pulse(0, 1'b1, 1'b1, 1'b1, 8'h10);
    pulse(0, 1'b1, 1'b1, 1'b0, 8'h10);
    start[0] = 1'b0;
    cyc(2);
    chk("halt_hold_pc", 0, 32'(pc[0]), 32'h82);
    chk("halt_hold_busy", 0, 32'(busy[0]), 32'd0);

    // reset in the middle of a fetch
    rst[0] = 1'b1; cyc(1); rst[0] = 1'b0;
    start[0] = 1'b1; cyc(1); start[0] = 1'b0; cyc(1);
    rst[0] = 1'b1; cyc(1); rst[0] = 1'b0;
    chk("midrst_busy", 0, 32'(busy[0]), 32'd0);
    chk("midrst_pc", 0, 32'(pc[0]), 32'd0);
    cyc(6);
    chk("midrst_ir_valid", 0, 32'(ir_valid[0]), 32'd0);
    chk("midrst_ir", 0, 32'(ir[0]), 32'd0);
    measure(0, e);
    chk("restart_edges", 0, 32'(e), 32'd4);
    chk("restart_ir", 0, 32'(ir[0]), 32'd1);

    // MEM_LAT=1, START_ADDR=FF: wrap then halt
    measure(1, e);
    chk("lat1_edges", 1, 32'(e), 32'd3);
    chk("wrap_ir", 1, 32'(ir[1]), 32'd1);
    chk("wrap_pc", 1, 32'(pc[1]), 32'd0);
    pulse(1, 1'b1, 1'b0, 1'b0, 8'h00);
    wait_valid(1);
    chk("lat1_halt", 1, 32'(halted[1]), 32'd1);
    chk("lat1_halt_ir", 1, 32'(ir[1]), 32'd28);
    chk("lat1_halt_pc", 1, 32'(pc[1]), 32'd1);

    // MEM_LAT=4
    measure(2, e);
    chk("lat4_edges", 2, 32'(e), 32'd6);
    chk("lat4_ir", 2, 32'(ir[2]), 32'h55);

    cyc(2);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Program-counter and instruction-register stage directly upstream of control_unit.
- Fetches 8-bit opcodes from instruction memory and presents a stable ir while control_unit executes.
- Applies control_unit's PC increment and jump requests, and halts on ENDOP.
- One fetch takes 1+MEM_LAT cycles: 3 cycles at the default, matching the 3-cycle fetch window control_unit expects.

Parameters:
- ADDR_W, 8, instruction memory address / PC width.
- DATA_W, 8, opcode width (ir width).
- MEM_LAT, 2, instruction memory read latency in cycles; legal range 1..4.
- START_ADDR, 0, PC value loaded on start.
- ENDOP_CODE, 28, opcode that halts fetching.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin fetching from START_ADDR; honoured only in IDLE.
- im_addr  out  ADDR_W  instruction memory read address.
- im_rd  out  1  instruction memory read strobe.
- im_data  in  DATA_W  instruction memory read data.
- exec_done  in  1  one-cycle pulse from control_unit: current instruction finished.
- pc_inc  in  1  advance PC by 1 (operand skip), valid in EXEC.
- pc_load  in  1  jump request, valid in EXEC.
- pc_load_val  in  ADDR_W  jump target.
- ir  out  DATA_W  current instruction to control_unit.
- ir_valid  out  1  ir holds a freshly fetched instruction.
- pc  out  ADDR_W  program counter.
- busy  out  1  high in F_ADDR/F_WAIT.
- halted  out  1  ENDOP reached.
- instr_count  out  16  instructions fetched since start.

Behaviour:
- Reset (rst sampled high at an edge, any state, including mid-fetch): state=IDLE, pc=0, ir=0, ir_valid=0, im_addr=0, im_rd=0, busy=0, halted=0, instr_count=0. Any in-flight memory data is discarded.
- States: IDLE, F_ADDR, F_WAIT, EXEC, HALT.
- IDLE: outputs at reset values. On start=1 → pc<=START_ADDR, instr_count<=0, → F_ADDR.
- F_ADDR (1 cycle): im_addr=pc, im_rd=1, busy=1, ir_valid=0 → F_WAIT. im_addr stays at this value until the fetch completes.
- F_WAIT (exactly MEM_LAT cycles, internal counter): im_rd=0, busy=1.
  - At the edge ending the last F_WAIT cycle: ir<=im_data, pc<=pc+1, instr_count<=instr_count+1.
  - If im_data==ENDOP_CODE → HALT, else → EXEC.
- Fetch latency: start edge to ir_valid high = 1+MEM_LAT+1 edges. With MEM_LAT=2, ir_valid rises 4 edges after start.
- EXEC: ir_valid=1, ir held stable.
  - pc_load=1 → pc<=pc_load_val.
  - Else pc_inc=1 → pc<=pc+1.
  - If both are high the same cycle, pc_load wins and pc_inc is ignored.
  - exec_done=1 → F_ADDR next cycle. A pc_load or pc_inc in the same cycle as exec_done applies first, so the next fetch uses the updated pc.
- HALT: halted=1, ir=ENDOP_CODE, ir_valid=1, busy=0. All inputs except rst are ignored; only rst exits HALT.
- Ignored inputs:
  - start outside IDLE.
  - exec_done, pc_inc, pc_load outside EXEC.
- Wrap-around: pc increments modulo 2^ADDR_W (2^ADDR_W-1 → 0, no flag). instr_count saturates at 16'hFFFF.
- im_data is sampled only at the final F_WAIT edge. Its value at any other time has no effect.

Test Plan:
- Reset then start, memory [0]=1, [1]=2, MEM_LAT=2 → im_rd pulses 1 cycle with im_addr=0. 4 edges after start: ir=1, ir_valid=1, pc=1. After exec_done: ir=2, pc=2, instr_count=2.
- In EXEC, pc_inc pulse then exec_done → next fetch address = pc+2 relative to the previous opcode address (operand skipped).
- Opcode 27 fetched, pc_load=1 with pc_load_val=8'h40 in the same cycle as exec_done → next im_addr=8'h40, pc=8'h41 after the fetch. Repeat with pc_load and pc_inc both high → pc_load wins.
- Start with START_ADDR=8'hFF, [FF]=1, [00]=28 → pc wraps 8'hFF→8'h00. ENDOP fetched → halted=1, ir=28, ir_valid=1. Further start/exec_done have no effect.
- Assert rst during F_WAIT → next cycle all outputs at reset values, state IDLE, later im_data ignored. A new start fetches from START_ADDR.
- MEM_LAT=1 and MEM_LAT=4 builds → ir_valid rises 3 and 6 edges after start respectively, and ir matches the memory contents.
